// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared types and defaults for the fetch PC generator
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_PRED,
    SRC_JAL,
    SRC_JALR,
    SRC_FILL,
    SRC_PREFAIL,
    SRC_HOLD
  } pc_src_e;

  typedef enum logic {
    RUN,
    HOLD
  } fsm_e;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - predictor, redirect and status signals of the fetch PC generator
interface fetch_pc_gen_if #(parameter int CNT_W = 32);
  logic              stall_f;
  logic [31:0]       pc_pre;
  logic              pc_sel;
  logic              btb_prefail;
  logic              btb_fill;
  logic [31:0]       pce;
  logic [31:0]       branch_target;
  logic [2:0]        branch_type_e;
  logic              jalr_e;
  logic [31:0]       jalr_target_e;
  logic              jal_d;
  logic [31:0]       jal_target_d;
  logic [31:0]       pcf;
  logic              flush_d;
  logic              flush_e;
  logic              redirect_held;
  logic [CNT_W-1:0]  perf_branch;
  logic [CNT_W-1:0]  perf_mispred;

  modport master (
    output stall_f, pc_pre, pc_sel, btb_prefail, btb_fill, pce, branch_target,
           branch_type_e, jalr_e, jalr_target_e, jal_d, jal_target_d,
    input  pcf, flush_d, flush_e, redirect_held, perf_branch, perf_mispred
  );

  modport slave (
    input  stall_f, pc_pre, pc_sel, btb_prefail, btb_fill, pce, branch_target,
           branch_type_e, jalr_e, jalr_target_e, jal_d, jal_target_d,
    output pcf, flush_d, flush_e, redirect_held, perf_branch, perf_mispred
  );
endinterface

// File: rtl/fetch_pc_gen_sat_counter.sv
// rtl/fetch_pc_gen_sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - owns PCF, picks the next fetch address, raises flushes
// and parks redirects that land while fetch is stalled.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_gen_if.slave   bus
);

  fsm_e        state, state_n;
  pc_src_e     pc_src;
  logic [31:0] pcf_q, pcf_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] next_pc;
  logic        ex_redirect;
  logic        any_redirect;

  assign ex_redirect  = bus.btb_prefail | bus.btb_fill | bus.jalr_e;
  assign any_redirect = ex_redirect | bus.jal_d;

  assign bus.flush_d       = any_redirect;
  assign bus.flush_e       = ex_redirect;
  assign bus.pcf           = pcf_q;
  assign bus.redirect_held = (state == HOLD);

  // In HOLD the parked target outranks prediction and sequential fetch.
  always_comb begin
    pc_src = SRC_SEQ;
    if (bus.btb_prefail)    pc_src = SRC_PREFAIL;
    else if (bus.btb_fill)  pc_src = SRC_FILL;
    else if (bus.jalr_e)    pc_src = SRC_JALR;
    else if (bus.jal_d)     pc_src = SRC_JAL;
    else if (state == HOLD) pc_src = SRC_HOLD;
    else if (bus.pc_sel)    pc_src = SRC_PRED;
  end

  always_comb begin
    next_pc = pcf_q + 32'd4;
    case (pc_src)
      SRC_PREFAIL: next_pc = bus.pce + 32'd4;
      SRC_FILL:    next_pc = bus.branch_target;
      SRC_JALR:    next_pc = bus.jalr_target_e & ~32'h1;
      SRC_JAL:     next_pc = bus.jal_target_d;
      SRC_HOLD:    next_pc = hold_pc;
      SRC_PRED:    next_pc = bus.pc_pre;
      default:     next_pc = pcf_q + 32'd4;
    endcase
  end

  always_comb begin
    state_n   = state;
    pcf_n     = pcf_q;
    hold_pc_n = hold_pc;
    case (state)
      RUN: begin
        if (!bus.stall_f) begin
          pcf_n = next_pc;
        end else if (any_redirect) begin
          hold_pc_n = next_pc;
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (!bus.stall_f) begin
          pcf_n   = next_pc;
          state_n = RUN;
        end else if (any_redirect) begin
          hold_pc_n = next_pc;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      pcf_q   <= RESET_PC;
      hold_pc <= 32'h0;
    end else begin
      state   <= state_n;
      pcf_q   <= pcf_n;
      hold_pc <= hold_pc_n;
    end
  end

  sat_counter #(.W(CNT_W)) u_perf_branch (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!bus.stall_f),
    .inc   (bus.branch_type_e != 3'd0),
    .count (bus.perf_branch)
  );

  sat_counter #(.W(CNT_W)) u_perf_mispred (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!bus.stall_f),
    .inc   (bus.btb_prefail | bus.btb_fill),
    .count (bus.perf_mispred)
  );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen with a behavioural model
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          CW     = 4;
  localparam int          CMAX   = (1 << CW) - 1;

  typedef struct {
    logic        rst_n;
    logic        stall_f;
    logic [31:0] pc_pre;
    logic        pc_sel;
    logic        btb_prefail;
    logic        btb_fill;
    logic [31:0] pce;
    logic [31:0] branch_target;
    logic [2:0]  branch_type_e;
    logic        jalr_e;
    logic [31:0] jalr_target_e;
    logic        jal_d;
    logic [31:0] jal_target_d;
  } stim_t;

  typedef struct {
    logic        flush_d;
    logic        flush_e;
    logic [31:0] pcf;
    logic        held;
    int          pb;
    int          pm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_gen_if #(.CNT_W(CW)) bus ();

  fetch_pc_gen #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Architectural model: PC, a pending parked redirect, and two event tallies.
  logic [31:0] m_pcf;
  logic        m_held;
  logic [31:0] m_hold;
  int          m_pb;
  int          m_pm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.stall_f = 1'b0; s.pc_pre = 32'h0; s.pc_sel = 1'b0;
    s.btb_prefail = 1'b0; s.btb_fill = 1'b0; s.pce = 32'h0; s.branch_target = 32'h0;
    s.branch_type_e = 3'd0; s.jalr_e = 1'b0; s.jalr_target_e = 32'h0;
    s.jal_d = 1'b0; s.jal_target_d = 32'h0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    ev;
    s = idle();
    s.rst_n         = ($urandom_range(0, 49) != 0);
    s.stall_f       = ($urandom_range(0, 3) == 0);
    s.pc_pre        = $urandom & ~32'h3;
    s.pc_sel        = $urandom_range(0, 1) == 1;
    s.pce           = $urandom;
    s.branch_target = $urandom & ~32'h1;
    s.branch_type_e = 3'($urandom_range(0, 7));
    s.jalr_target_e = $urandom;
    s.jal_target_d  = $urandom & ~32'h1;
    ev = $urandom_range(0, 9);
    if (ev == 0) s.btb_prefail = 1'b1;
    if (ev == 1) s.btb_fill = 1'b1;
    if (ev == 2 || ($urandom_range(0, 15) == 0)) s.jalr_e = 1'b1;
    if ($urandom_range(0, 5) == 0) s.jal_d = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t        e;
    logic        redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst_n             = s.rst_n;
    bus.stall_f       = s.stall_f;
    bus.pc_pre        = s.pc_pre;
    bus.pc_sel        = s.pc_sel;
    bus.btb_prefail   = s.btb_prefail;
    bus.btb_fill      = s.btb_fill;
    bus.pce           = s.pce;
    bus.branch_target = s.branch_target;
    bus.branch_type_e = s.branch_type_e;
    bus.jalr_e        = s.jalr_e;
    bus.jalr_target_e = s.jalr_target_e;
    bus.jal_d         = s.jal_d;
    bus.jal_target_d  = s.jal_target_d;

    e.flush_e = s.btb_prefail | s.btb_fill | s.jalr_e;
    e.flush_d = e.flush_e | s.jal_d;

    redir = 1'b1;
    if (s.btb_prefail)   tgt = s.pce + 32'd4;
    else if (s.btb_fill) tgt = s.branch_target;
    else if (s.jalr_e)   tgt = {s.jalr_target_e[31:1], 1'b0};
    else if (s.jal_d)    tgt = s.jal_target_d;
    else begin redir = 1'b0; tgt = 32'h0; end

    if (!s.rst_n) begin
      m_pcf = RST_PC; m_held = 1'b0; m_hold = 32'h0; m_pb = 0; m_pm = 0;
    end else if (s.stall_f) begin
      if (redir) begin m_held = 1'b1; m_hold = tgt; end
    end else begin
      if (redir)       m_pcf = tgt;
      else if (m_held) m_pcf = m_hold;
      else if (s.pc_sel) m_pcf = s.pc_pre;
      else             m_pcf = m_pcf + 32'd4;
      m_held = 1'b0;
      if (s.branch_type_e != 0 && m_pb < CMAX) m_pb++;
      if ((s.btb_prefail || s.btb_fill) && m_pm < CMAX) m_pm++;
    end
    e.pcf = m_pcf; e.held = m_held; e.pb = m_pb; e.pm = m_pm;
    sb_q.push_back(e);
  endtask

  // Monitor: flushes checked mid-cycle, registered state checked after the edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        check("flush_d", {31'h0, bus.flush_d}, {31'h0, cur.flush_d});
        check("flush_e", {31'h0, bus.flush_e}, {31'h0, cur.flush_e});
        @(posedge clk);
        #2;
        check("pcf", bus.pcf, cur.pcf);
        check("redirect_held", {31'h0, bus.redirect_held}, {31'h0, cur.held});
        check("perf_branch", {28'h0, bus.perf_branch}, 32'(cur.pb));
        check("perf_mispred", {28'h0, bus.perf_mispred}, 32'(cur.pm));
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b1;
    s = idle();
    bus.stall_f = 0; bus.pc_pre = 0; bus.pc_sel = 0; bus.btb_prefail = 0;
    bus.btb_fill = 0; bus.pce = 0; bus.branch_target = 0; bus.branch_type_e = 0;
    bus.jalr_e = 0; bus.jalr_target_e = 0; bus.jal_d = 0; bus.jal_target_d = 0;
    m_pcf = 32'h0; m_held = 1'b0; m_hold = 32'h0; m_pb = 0; m_pm = 0;

    s = idle(); s.rst_n = 1'b0; apply(s); apply(s);
    s = idle(); apply(s); apply(s);
    s = idle(); s.jal_d = 1'b1; s.jal_target_d = 32'h200; apply(s);
    s = idle(); s.pc_sel = 1'b1; s.pc_pre = 32'h400; apply(s);
    s = idle(); s.btb_prefail = 1'b1; s.pce = 32'h300; s.jal_d = 1'b1;
    s.jal_target_d = 32'h999; s.branch_type_e = 3'd1; apply(s);
    s = idle(); s.stall_f = 1'b1; s.btb_fill = 1'b1; s.branch_target = 32'h800;
    s.branch_type_e = 3'd2;
    repeat (3) apply(s);
    s = idle(); apply(s);
    s = idle(); s.stall_f = 1'b1; s.btb_fill = 1'b1; s.branch_target = 32'h800;
    apply(s); apply(s);
    s = idle(); s.rst_n = 1'b0; s.stall_f = 1'b1; apply(s);
    s = idle(); apply(s);
    s = idle(); s.jal_d = 1'b1; s.jal_target_d = 32'hFFFF_FFFC; apply(s);
    s = idle(); apply(s);
    for (int i = 0; i < 20; i++) begin
      s = idle(); s.btb_prefail = 1'b1; s.pce = $urandom; s.branch_type_e = 3'd5;
      apply(s);
    end
    s = idle(); s.stall_f = 1'b1; s.jal_d = 1'b1; s.jal_target_d = 32'h1000; apply(s);
    s = idle(); s.stall_f = 1'b1; s.jalr_e = 1'b1; s.jalr_target_e = 32'h2001;
    s.jal_d = 1'b1; s.jal_target_d = 32'h3000; apply(s);
    s = idle(); s.stall_f = 1'b1; s.pc_sel = 1'b1; s.pc_pre = 32'h4000; apply(s);
    s = idle(); s.pc_sel = 1'b1; s.pc_pre = 32'h4000; apply(s);

    for (int i = 0; i < 400; i++) apply(rand_stim());

    repeat (4) @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage PC generator: owns the PCF register and selects the next fetch address. Consumes the branch predictor's IF-stage prediction (PC_PRE/PC_SEL) and its EX-stage correction signals (btb_prefail/btb_fill/PCE) together with JAL/JALR resolution. Emits the D/E flush requests and holds any redirect that arrives during a fetch stall. Also keeps saturating branch and mispredict counters for lab statistics.

## Interface
- RESET_PC, 32'h0000_0000, PCF value after reset
- CNT_W, 32, width of each performance counter

- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- stall_f  in  1  hazard unit: hold PCF this cycle
- pc_pre  in  32  predicted target for current PCF
- pc_sel  in  1  predictor says taken for current PCF
- btb_prefail  in  1  EX branch predicted taken, actually not taken
- btb_fill  in  1  EX branch taken but not predicted taken
- pce  in  32  PC of the EX-stage instruction
- branch_target  in  32  EX-stage computed branch target
- branch_type_e  in  3  nonzero = conditional branch in EX
- jalr_e  in  1  JALR in EX
- jalr_target_e  in  32  JALR target
- jal_d  in  1  JAL in ID
- jal_target_d  in  32  JAL target
- pcf  out  32  current fetch PC (register)
- flush_d  out  1  kill ID-stage instruction
- flush_e  out  1  kill EX-stage instruction
- redirect_held  out  1  HOLD state indicator
- perf_branch  out  CNT_W  conditional branches retired from EX
- perf_mispred  out  CNT_W  branch mispredictions

## Operation
- Next-PC priority (highest first): btb_prefail -> pce+4; btb_fill -> branch_target; jalr_e -> {jalr_target_e[31:1],1'b0}; jal_d -> jal_target_d; pc_sel -> pc_pre; else pcf+4. All adds modulo 2^32 (0xFFFF_FFFC+4 = 0).
- ex_redirect = btb_prefail | btb_fill | jalr_e. ex_redirect -> flush_d=1, flush_e=1. jal_d without ex_redirect -> flush_d=1, flush_e=0. Flushes are combinational and independent of stall_f.
- btb_prefail and btb_fill simultaneously is illegal; prefail wins if seen.
- FSM, two states:
  - RUN: stall_f=0 -> pcf <= selected next PC. stall_f=1 with ex_redirect or jal_d -> capture selected target into hold_pc, go HOLD; pcf unchanged.
  - HOLD: redirect_held=1. New ex_redirect or jal_d while stall_f=1 overwrites hold_pc (newest wins; EX beats ID same cycle). stall_f=0: pcf <= ex_redirect/jal_d target if present this cycle, else hold_pc; go RUN. Prediction and pcf+4 never used in HOLD.
- Counters advance only when stall_f=0: perf_branch += (branch_type_e!=0); perf_mispred += (btb_prefail|btb_fill). Saturate at all-ones, no wrap.
- Reset (rst_n=0 at posedge, overrides everything): pcf=RESET_PC, state=RUN, hold_pc=0, redirect_held=0, both counters 0. Reset mid-HOLD discards hold_pc. flush_d/flush_e follow inputs combinationally, also during reset.

## Timing
- Redirect latency: ex_redirect at cycle N with stall_f=0 -> pcf = target at N+1.
- Redirect during stall: captured at N, applied at first posedge with stall_f=0; pcf holds throughout.
- pc_sel/pc_pre sampled same cycle as pcf they refer to; predictor lookup is combinational from pcf.
- Counters visible one cycle after the counted event.

## Structure
- Package fetch_pkg: RESET_PC default, pc_src_e enum {SRC_SEQ, SRC_PRED, SRC_JAL, SRC_JALR, SRC_FILL, SRC_PREFAIL, SRC_HOLD}, fsm_e {RUN, HOLD}.
- One sub-module: sat_counter (param W, inc, en) instantiated twice for the perf counters.
- Next-PC mux as a priority encoder producing pc_src_e, then one case on it.

## Test plan
- Reset: rst_n=0 two cycles, RESET_PC=0x100 -> pcf=0x100, counters 0, redirect_held=0; then stall_f=0 no events -> 0x104, 0x108.
- Prediction: pcf=0x200, pc_sel=1, pc_pre=0x400 -> next pcf=0x400, no flush.
- Prefail vs jal: btb_prefail=1, pce=0x300, jal_d=1 same cycle -> pcf=0x304, flush_d=flush_e=1, perf_mispred=1.
- Stall capture: stall_f=1, btb_fill=1, branch_target=0x800 for 3 cycles -> pcf unchanged, redirect_held=1, counters unchanged; stall_f=0 -> pcf=0x800, state RUN.
- Reset mid-HOLD: HOLD with hold_pc=0x800, rst_n=0 -> pcf=RESET_PC, redirect_held=0, target never applied.
- Wrap/saturation: pcf=0xFFFF_FFFC sequential -> 0x0; CNT_W=4, 20 mispredicts -> perf_mispred=15.
